pipe_add: RTL

PIPE_ADD -- requirements
Module: pipe_add

---
 rtl/pipe_add_pkg.sv | 13 +
 rtl/add_chunk.sv | 23 ++
 rtl/pipe_add.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipe_add_pkg.sv
// Shared defaults and stage-count derivation for the chunked pipelined adder.
package pipe_add_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CHUNK = 8;

    function automatic int unsigned calc_stages(input int unsigned width, input int unsigned chunk);
        if (chunk == 0 || width < chunk)
            return 1;
        return width / chunk;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit adder slice: sum, carry out and carry into the slice MSB.
module add_chunk
    import pipe_add_pkg::*;
#(
    parameter int unsigned W = DEF_CHUNK
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] s_o,
    output logic         co_o,
    output logic         cm_o
);

    logic [W:0] sum;

    assign sum  = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
    assign s_o  = sum[W-1:0];
    assign co_o = sum[W];
    // Recover the carry into the MSB from the sum bit and both operand bits.
    assign cm_o = sum[W-1] ^ a_i[W-1] ^ b_i[W-1];

endmodule

// File: rtl/pipe_add.sv
// Ripple-carry adder/subtractor pipelined CHUNK bits per stage, with valid/ready
// flow control and skew/deskew of the operand and sum chunks.
module pipe_add
    import pipe_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V
);

    localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("pipe_add: WIDTH must be a positive multiple of CHUNK");
    end

    logic             en;
    logic [WIDTH-1:0] op_a [STAGES];
    logic [WIDTH-1:0] op_b [STAGES];
    logic             op_c [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic             v_in [STAGES];
    logic [WIDTH-1:0] s_d  [STAGES];
    logic             c_d  [STAGES];
    logic             m_d  [STAGES];
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] b_q  [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic             c_q  [STAGES];
    logic             v_q  [STAGES];
    logic             m_q;

    assign en       = !OUT_VALID || OUT_READY;
    assign IN_READY = en;

    // Subtraction is folded in at entry (invert B, force carry-in), so later
    // stages see a plain add; a_q/b_q carry the still-pending upper chunks
    // and s_q the already-finished lower sum chunks.
    always_comb begin
        op_a[0] = A;
        op_b[0] = SUB ? ~B : B;
        op_c[0] = SUB ? 1'b1 : CI;
        s_in[0] = '0;
        v_in[0] = IN_VALID;
        for (int unsigned k = 1; k < STAGES; k++) begin
            op_a[k] = a_q[k-1];
            op_b[k] = b_q[k-1];
            op_c[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] sum_chunk;
        logic [WIDTH-1:0] s_nxt;

        add_chunk #(.W(CHUNK)) u_add (
            .a_i  (op_a[k][k*CHUNK +: CHUNK]),
            .b_i  (op_b[k][k*CHUNK +: CHUNK]),
            .ci_i (op_c[k]),
            .s_o  (sum_chunk),
            .co_o (c_d[k]),
            .cm_o (m_d[k])
        );

        always_comb begin
            s_nxt                     = s_in[k];
            s_nxt[k*CHUNK +: CHUNK]   = sum_chunk;
        end

        assign s_d[k] = s_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
            end
            s_q[STAGES-1] <= '0;
            c_q[STAGES-1] <= 1'b0;
            m_q           <= 1'b0;
        end else if (en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                a_q[k] <= op_a[k];
                b_q[k] <= op_b[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
            m_q <= m_d[STAGES-1];
        end
    end

    assign OUT_VALID = v_q[STAGES-1];
    assign S         = s_q[STAGES-1];
    assign C         = c_q[STAGES-1];
    assign V         = c_q[STAGES-1] ^ m_q;

endmodule
